// File: rtl/sampler_stream_pkg.sv
// Shared types and TUSER field layout for the per-voice sample streamer.
package sampler_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    STREAM = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam int VOICE_LSB = 0;
  localparam int VOICE_W   = 6;
  localparam int LAST_BIT  = 6;
  localparam int DEF_SAMPLES_PER_STREAM = 64;
  localparam logic [31:0] STOP_TUSER = 32'hFFFF_FFFF;

endpackage

// File: rtl/sampler_stream_skid_fifo.sv
// Two-entry fall-through AXIS buffer: an arriving word is visible on the output
// in the same cycle when the buffer is empty, and is stored if not taken.
module sampler_stream_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         has_data_s;
  logic         write_s;
  logic         read_s;

  // Output select and bypass: a word consumed straight from the input is never stored.
  always_comb begin
    has_data_s  = (count_q != 2'd0);
    out_valid_o = has_data_s | push_i;
    out_data_o  = has_data_s ? mem_q[rd_ptr_q] : push_data_i;
    read_s      = pop_i & has_data_s;
    write_s     = push_i & ~(~has_data_s & pop_i);
    count_o     = count_q;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= {W{1'b0}};
      mem_q[1] <= {W{1'b0}};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (write_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (read_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, write_s} - {1'b0, read_s};
    end
  end

endmodule

// File: rtl/sampler_voice_streamer.sv
// Per-voice sample streamer: one AXIS packet per active voice at each block tick.
// Optional statistics ports are enabled with SAMPLER_STREAMER_STATS_EN.
module sampler_voice_streamer
  import sampler_stream_pkg::*;
#(
  parameter int C_AXI_STREAM_TDATA_WIDTH = 32,
  parameter int C_AXI_STREAM_TUSER_WIDTH = 32,
  parameter int MAX_VOICES               = 64,
  parameter int SAMPLES_PER_STREAM       = DEF_SAMPLES_PER_STREAM
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                block_tick,
  input  logic [MAX_VOICES-1:0]               voice_active,
  input  logic                                stop_req,
  output logic                                rd_en,
  output logic [VOICE_W-1:0]                  rd_voice,
  output logic [$clog2(SAMPLES_PER_STREAM)-1:0] rd_idx,
  input  logic [C_AXI_STREAM_TDATA_WIDTH-1:0] rd_data,
  output logic [C_AXI_STREAM_TDATA_WIDTH-1:0] axi_stream_master_tdata,
  output logic                                axi_stream_master_tvalid,
  output logic                                axi_stream_master_tlast,
  output logic [C_AXI_STREAM_TUSER_WIDTH-1:0] axi_stream_master_tuser,
  input  logic                                axi_stream_master_tready,
  output logic                                busy,
  output logic                                overrun
`ifdef SAMPLER_STREAMER_STATS_EN
  ,
  output logic [31:0]                         blocks_sent,
  output logic [15:0]                         overrun_cnt
`endif
);

  localparam int DW = C_AXI_STREAM_TDATA_WIDTH;
  localparam int TW = C_AXI_STREAM_TUSER_WIDTH;
  localparam int IW = $clog2(SAMPLES_PER_STREAM);
  localparam logic [IW:0]   SPS_C       = (IW+1)'(SAMPLES_PER_STREAM);
  localparam logic [IW-1:0] LAST_BEAT_C = IW'(SAMPLES_PER_STREAM - 1);

  state_e                  state_q;
  logic [MAX_VOICES-1:0]   pending_q;
  logic [VOICE_W-1:0]      voice_q;
  logic                    last_q, silent_q, iss_q, arr_q, rd_en_q, overrun_q;
  logic [IW-1:0]           rd_idx_q, beat_cnt_q;
  logic [IW:0]             iss_cnt_q;
  logic [MAX_VOICES-1:0]   pick_s, rest_s;
  logic [VOICE_W-1:0]      pick_idx_s;
  logic                    stop_s, tick_overrun_s, fifo_push_s, fifo_valid_s;
  logic                    beat_done_s, pkt_end_s, credit_ok_s, issue_s;
  logic [DW-1:0]           fifo_push_data_s, fifo_data_s;
  logic [1:0]              fifo_count_s;
  logic [2:0]              load_s;
  logic [TW-1:0]           pkt_user_s;

  function automatic logic [VOICE_W-1:0] lowest_set(input logic [MAX_VOICES-1:0] m);
    logic [VOICE_W-1:0] idx;
    idx = {VOICE_W{1'b0}};
    for (int i = MAX_VOICES - 1; i >= 0; i--) begin
      if (m[i]) idx = VOICE_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  // Voice selection, read credit and packet bookkeeping.
  always_comb begin
    pick_idx_s       = lowest_set(pending_q);
    pick_s           = {{(MAX_VOICES-1){1'b0}}, 1'b1} << pick_idx_s;
    rest_s           = pending_q & ~pick_s;
    stop_s           = stop_req & (state_q != STOP);
    tick_overrun_s   = block_tick & ~stop_req & (state_q != IDLE);
    fifo_push_s      = arr_q & (state_q == STREAM);
    fifo_push_data_s = silent_q ? {DW{1'b0}} : rd_data;
    beat_done_s      = (state_q == STREAM) & fifo_valid_s & axi_stream_master_tready;
    pkt_end_s        = beat_done_s & (beat_cnt_q == LAST_BEAT_C);
    // Reads still owed to the buffer: stored words plus the two pipeline stages.
    load_s           = {1'b0, fifo_count_s} + {2'b00, iss_q} + {2'b00, arr_q};
    credit_ok_s      = load_s < (3'd2 + {2'b00, beat_done_s});
    issue_s          = (state_q == STREAM) & (iss_cnt_q < SPS_C) & credit_ok_s;
    pkt_user_s                         = {TW{1'b0}};
    pkt_user_s[VOICE_LSB +: VOICE_W]   = voice_q;
    pkt_user_s[LAST_BIT]               = last_q;
  end

  // AXIS output mux: sample beats from the buffer, or the fixed stop beat.
  always_comb begin
    axi_stream_master_tvalid = 1'b0;
    axi_stream_master_tdata  = {DW{1'b0}};
    axi_stream_master_tlast  = 1'b0;
    axi_stream_master_tuser  = {TW{1'b0}};
    case (state_q)
      STREAM: begin
        axi_stream_master_tvalid = fifo_valid_s;
        axi_stream_master_tdata  = fifo_data_s;
        axi_stream_master_tlast  = fifo_valid_s & (beat_cnt_q == LAST_BEAT_C);
        axi_stream_master_tuser  = pkt_user_s;
      end
      STOP: begin
        axi_stream_master_tvalid = 1'b1;
        axi_stream_master_tlast  = 1'b1;
        axi_stream_master_tuser  = TW'(STOP_TUSER);
      end
      default: begin
        axi_stream_master_tvalid = 1'b0;
      end
    endcase
  end

  assign rd_en    = rd_en_q;
  assign rd_voice = voice_q;
  assign rd_idx   = rd_idx_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;

  sampler_stream_skid_fifo #(.W(DW)) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (stop_s),
    .push_i      (fifo_push_s),
    .push_data_i (fifo_push_data_s),
    .pop_i       (beat_done_s),
    .out_valid_o (fifo_valid_s),
    .out_data_o  (fifo_data_s),
    .count_o     (fifo_count_s)
  );

  // Block sequencer: voice scan, read issue and packet completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pending_q  <= {MAX_VOICES{1'b0}};
      voice_q    <= {VOICE_W{1'b0}};
      last_q     <= 1'b0;
      silent_q   <= 1'b0;
      iss_q      <= 1'b0;
      arr_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_idx_q   <= {IW{1'b0}};
      iss_cnt_q  <= {(IW+1){1'b0}};
      beat_cnt_q <= {IW{1'b0}};
      overrun_q  <= 1'b0;
    end else begin
      iss_q   <= 1'b0;
      rd_en_q <= 1'b0;
      arr_q   <= iss_q;
      if (tick_overrun_s) overrun_q <= 1'b1;
      if (stop_s) begin
        state_q   <= STOP;
        pending_q <= {MAX_VOICES{1'b0}};
        arr_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (block_tick) begin
              pending_q <= voice_active;
              state_q   <= SCAN;
            end
          end
          SCAN: begin
            if (pending_q == {MAX_VOICES{1'b0}}) begin
              voice_q  <= {VOICE_W{1'b0}};
              last_q   <= 1'b1;
              silent_q <= 1'b1;
            end else begin
              voice_q   <= pick_idx_s;
              pending_q <= rest_s;
              last_q    <= (rest_s == {MAX_VOICES{1'b0}});
              silent_q  <= 1'b0;
            end
            iss_q      <= 1'b1;
            rd_en_q    <= (pending_q != {MAX_VOICES{1'b0}});
            rd_idx_q   <= {IW{1'b0}};
            iss_cnt_q  <= {{IW{1'b0}}, 1'b1};
            beat_cnt_q <= {IW{1'b0}};
            state_q    <= STREAM;
          end
          STREAM: begin
            if (issue_s) begin
              iss_q     <= 1'b1;
              rd_en_q   <= ~silent_q;
              rd_idx_q  <= iss_cnt_q[IW-1:0];
              iss_cnt_q <= iss_cnt_q + {{IW{1'b0}}, 1'b1};
            end
            if (beat_done_s) beat_cnt_q <= beat_cnt_q + {{(IW-1){1'b0}}, 1'b1};
            if (pkt_end_s) begin
              if (pending_q != {MAX_VOICES{1'b0}}) state_q <= SCAN;
              else                                 state_q <= IDLE;
            end
          end
          STOP: begin
            if (axi_stream_master_tready) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef SAMPLER_STREAMER_STATS_EN
  // Completed blocks and saturating overrun events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blocks_sent <= 32'd0;
      overrun_cnt <= 16'd0;
    end else begin
      if (pkt_end_s && last_q && !stop_s) blocks_sent <= blocks_sent + 32'd1;
      if (tick_overrun_s && (overrun_cnt != 16'hFFFF)) overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

endmodule
